avr_mem_arbiter: RTL
====================

# avr_mem_arbiter

Shares one internal byte-wide memory/register bus between two masters: the AVR parallel port (requester A) and a second on-chip master such as DMA or video (requester B). It serialises accesses, registers read data, pulses a per-requester acknowledge, and drives the port's ready/busy line so the AVR waits while its access is pending. It sits between the AVR port's address/data decode and the memory-side slave.

## Interface
- AW, 24, address width
- DW, 8, data width
- A_PRIORITY, 0, 1 = A always wins contention; 0 = round-robin
- TIMEOUT, 255, cycles to wait for mem_ack before forced completion (only with timeout feature)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  A access request, level, held until a_ack
- a_we  in  1  A write (1) / read (0), stable while a_req
- a_addr  in  AW  A address, stable while a_req
- a_wdata  in  DW  A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  DW  A read data, valid with a_ack, held until next A read
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A for requester B
- mem_req  out  1  slave request, held until mem_ack
- mem_we  out  1  slave write enable
- mem_addr  out  AW  slave address
- mem_wdata  out  DW  slave write data
- mem_rdata  in  DW  slave read data, sampled with mem_ack
- mem_ack  in  1  slave completion, may arrive in first mem_req cycle
- r_n_b  out  1  AVR ready (1) / busy (0)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: at a clock edge with any req high, pick winner; latch we/addr/wdata into mem_* regs; record owner; go ACCESS.
- Winner: only one req -> it. Both: A_PRIORITY=1 -> A; else the one not granted last (pointer resets to "B last", so A wins first contention).
- ACCESS: mem_req=1. On edge with mem_ack=1: capture mem_rdata into owner's rdata (reads only), go DONE.
- DONE: owner's ack=1 for exactly this cycle; mem_req=0; update round-robin pointer; go IDLE.
- Requester drops req on the edge sampling its ack; arbiter is in IDLE next cycle, so no double issue. req re-asserted that edge starts a new access.
- Requests arriving during ACCESS/DONE wait; never dropped.
- Writes leave rdata unchanged.
- r_n_b: registered; cleared on the edge where a_req=1 and no a_ack is in progress; set on the edge entering DONE for A (r_n_b high in a_ack cycle).
- Reset (any time, including mid-access): state IDLE, mem_req/mem_we/a_ack/b_ack 0, mem_addr/mem_wdata/a_rdata/b_rdata 0, r_n_b 1, pointer "B last". Interrupted access is abandoned.

## Timing
- req high before edge 0 -> mem_req high cycle 1.
- mem_ack in cycle 1 -> ack high cycle 2 (minimum latency 2 cycles), mem_req low in cycle 2.
- mem_ack in cycle n -> ack in cycle n+1.
- Back-to-back: next mem_req earliest 2 cycles after previous mem_ack (DONE + IDLE).
- Both req at edge 0, round-robin: A gets ack cycle 2; B mem_req cycle 4 at earliest.

## Configuration
- AVR_ARB_TIMEOUT_EN defined: counter cleared on ACCESS entry, increments each ACCESS cycle without mem_ack; at TIMEOUT it forces DONE, read returns all-ones (8'hFF), mem_req drops, ack pulses normally.
- Undefined: ACCESS waits indefinitely for mem_ack; no counter logic.

## Structure
- Package avr_pkg: state enum (IDLE/ACCESS/DONE), owner encoding (OWN_A/OWN_B), AVR_AW=24, AVR_DW=8 defaults.
- Sub-module avr_arb_timer: clear/enable timeout counter with terminal-count output; instantiated only under AVR_ARB_TIMEOUT_EN.

## Test plan
- A read 0x123456, slave returns 0x5A with mem_ack in cycle 1 -> mem_addr=0x123456, a_ack cycle 2, a_rdata=0x5A, r_n_b low cycles 1-1, high cycle 2.
- B write 0x000010 data 0xC3, mem_ack after 3 wait cycles -> mem_we=1, mem_wdata=0xC3 held 4 cycles, b_ack once, b_rdata unchanged.
- A and B req same edge, A_PRIORITY=0, repeated 4 times -> grant order A,B,A,B; A_PRIORITY=1 -> A served first each time.
- rst asserted during ACCESS -> all outputs reset values immediately (async), mem_req 0; after release, held req restarts cleanly.
- AVR_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks A read -> a_ack after 8 ACCESS cycles, a_rdata=0xFF, r_n_b returns high.
- Requester keeps req high one edge past ack -> exactly one additional access, not two.

Source files
------------

// File: rtl/avr_mem_arbiter_pkg.sv
// Shared types for the AVR memory arbiter: FSM states, bus owner encoding, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package avr_pkg;

    localparam int AVR_AW = 24;
    localparam int AVR_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Chooses the next bus owner; only meaningful when at least one request is high.
    // Under contention, fixed priority gives A the bus, otherwise whoever was not served last wins.
    function automatic owner_t pick_winner(input logic a_req, input logic b_req,
                                           input logic a_pri, input owner_t last);
        owner_t win;
        if (a_req && !b_req) begin
            win = OWN_A;
        end else if (b_req && !a_req) begin
            win = OWN_B;
        end else if (a_pri) begin
            win = OWN_A;
        end else begin
            win = (last == OWN_B) ? OWN_A : OWN_B;
        end
        return win;
    endfunction

endpackage

// File: rtl/avr_mem_arbiter_if.sv
// Requester channel and memory-slave channel bundles used by the AVR memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: requester holds req until ack; arbiter holds mem req until mem ack.
interface avr_req_if #(
    parameter int AW = 24,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

interface avr_mem_if #(
    parameter int AW = 24,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/avr_mem_arbiter_timer.sv
// Clear/enable cycle counter; tc_o flags the enabled cycle that reaches LIMIT counts.
// Latency: tc_o is combinational on the current count and enable.
// Backpressure: none; clr_i has priority over en_i.
module avr_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The LIMIT-th enabled cycle is the terminal one, so compare against LIMIT-1.
    assign tc_o = en_i && (cnt_q == CW'(LIMIT - 1));

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/avr_mem_arbiter.sv
// Two-master arbiter (AVR port A, on-chip master B) onto one byte-wide memory bus; optional AVR_ARB_TIMEOUT_EN.
// Latency: req->mem_req 1 cycle, mem_ack->requester ack 1 cycle (2 cycles minimum), 2 idle cycles between accesses.
// Backpressure: requesters hold req until their ack; losers wait, never dropped; r_n_b_o low while A waits.
module avr_mem_arbiter
    import avr_pkg::*;
#(
    parameter int AW         = AVR_AW,
    parameter int DW         = AVR_DW,
    parameter int A_PRIORITY = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    avr_req_if.slave   a_if,
    avr_req_if.slave   b_if,
    avr_mem_if.master  mem_if,
    output logic       r_n_b_o
);

    state_t        state_q,     state_d;
    owner_t        owner_q,     owner_d;
    owner_t        last_q,      last_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] a_rdata_q,   a_rdata_d;
    logic [DW-1:0] b_rdata_q,   b_rdata_d;
    logic          r_n_b_q,     r_n_b_d;

    logic          timeout_hit;
    logic          a_ack_now;
    logic          b_ack_now;
    logic [DW-1:0] rd_val;

`ifdef AVR_ARB_TIMEOUT_EN
    logic tmr_tc;

    // Counts ACCESS cycles without a slave ack; held clear whenever the bus is idle.
    avr_arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_IDLE),
        .en_i  ((state_q == ST_ACCESS) && !mem_if.ack),
        .tc_o  (tmr_tc)
    );

    assign timeout_hit = tmr_tc;
`else
    assign timeout_hit = 1'b0;
`endif

    assign a_ack_now = (state_q == ST_DONE) && (owner_q == OWN_A);
    assign b_ack_now = (state_q == ST_DONE) && (owner_q == OWN_B);

    // A real ack returns slave data; a forced completion reads back all-ones.
    assign rd_val = mem_if.ack ? mem_if.rdata : {DW{1'b1}};

    // Next-state and datapath updates for the IDLE -> ACCESS -> DONE cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (a_if.req || b_if.req) begin
                    owner_d = pick_winner(a_if.req, b_if.req, (A_PRIORITY != 0), last_q);
                    if (owner_d == OWN_A) begin
                        mem_we_d    = a_if.we;
                        mem_addr_d  = a_if.addr;
                        mem_wdata_d = a_if.wdata;
                    end else begin
                        mem_we_d    = b_if.we;
                        mem_addr_d  = b_if.addr;
                        mem_wdata_d = b_if.wdata;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_if.ack || timeout_hit) begin
                    state_d = ST_DONE;
                    if (!mem_we_q) begin
                        if (owner_q == OWN_A) begin
                            a_rdata_d = rd_val;
                        end else begin
                            b_rdata_d = rd_val;
                        end
                    end
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready/busy: raise as A's access completes, drop while A is requesting outside its ack cycle.
    always_comb begin
        r_n_b_d = r_n_b_q;
        if ((state_q == ST_ACCESS) && (state_d == ST_DONE) && (owner_q == OWN_A)) begin
            r_n_b_d = 1'b1;
        end else if (a_if.req && !a_ack_now) begin
            r_n_b_d = 1'b0;
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_A;
            last_q      <= OWN_B;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            r_n_b_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            r_n_b_q     <= r_n_b_d;
        end
    end

    assign mem_if.req   = (state_q == ST_ACCESS);
    assign mem_if.we    = mem_we_q;
    assign mem_if.addr  = mem_addr_q;
    assign mem_if.wdata = mem_wdata_q;

    assign a_if.ack   = a_ack_now;
    assign a_if.rdata = a_rdata_q;
    assign b_if.ack   = b_ack_now;
    assign b_if.rdata = b_rdata_q;

    assign r_n_b_o = r_n_b_q;

endmodule
